// File: rtl/demux1to4_5_buf_pkg.sv
// demux1to4_5_buf_pkg
//   Shared definitions for the 1-to-4 register-address demultiplexer:
//   destination channel codes, default payload width and the per-channel
//   holding-buffer state encoding.
package demux1to4_5_buf_pkg;

   // Destination channel codes carried on in_sel
   localparam logic [1:0] CH_WB    = 2'd0;  // write-back
   localparam logic [1:0] CH_DBG   = 2'd1;  // debug port
   localparam logic [1:0] CH_CP0   = 2'd2;  // CP0
   localparam logic [1:0] CH_SPARE = 2'd3;  // spare

   // Default payload width
   localparam int unsigned W_DEF = 5;

   // Single-entry holding buffer occupancy
   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

endpackage

// File: rtl/demux1to4_5_buf_buf1_5.sv
// buf1_5
//   Single-entry valid/ready holding register for one destination channel.
//   A load overwrites the entry and marks it full; a drain without a load
//   empties it. Data is held (not cleared) after draining.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   load        : write din into the entry on the next edge
//   din         : payload to store
//   out_ready   : consumer takes the entry this cycle
//   out_valid   : entry holds data
//   out_data    : stored payload
module buf1_5
   import demux1to4_5_buf_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   buf_state_e   state_q, state_d;
   logic [W-1:0] data_q,  data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BUF_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // A load wins over a simultaneous drain so the entry reloads and stays
   // full, giving one transfer per cycle.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      unique case (state_q)
         BUF_EMPTY: begin
            if (load) begin
               state_d = BUF_FULL;
               data_d  = din;
            end
         end
         BUF_FULL: begin
            if (load) begin
               data_d  = din;
            end else if (out_ready) begin
               state_d = BUF_EMPTY;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
   end

   assign out_valid = (state_q == BUF_FULL);
   assign out_data  = data_q;

endmodule

// File: rtl/demux1to4_5_buf.sv
// demux1to4_5_buf
//   Routes one W-bit transfer to one of four buffered destination channels
//   (write-back, debug, CP0, spare) selected by in_sel, with a valid/ready
//   handshake per channel and a count of accepted input transfers.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : source handshake
//   in_sel              : destination channel 0..3
//   in_data             : payload
//   out_valid[k]        : channel k buffer holds data
//   out_ready[k]        : channel k consumer takes data this cycle
//   out_data0..3        : per-channel payload (registered)
//   acc_cnt             : accepted-transfer count, wraps
module demux1to4_5_buf
   import demux1to4_5_buf_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [W-1:0]     in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [W-1:0]     out_data0,
   output logic [W-1:0]     out_data1,
   output logic [W-1:0]     out_data2,
   output logic [W-1:0]     out_data3,
   output logic [CNT_W-1:0] acc_cnt
);

   logic             accept;
   logic [3:0]       load;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

   // Only the selected channel's occupancy gates the source, so a stalled
   // channel never blocks traffic to the others.
   assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
   assign accept   = in_valid & in_ready;

   always_comb begin
      load         = '0;
      load[in_sel] = accept;
   end

   always_comb begin
      acc_cnt_d = acc_cnt_q;
      if (accept) begin
         acc_cnt_d = acc_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt_q <= '0;
      end else begin
         acc_cnt_q <= acc_cnt_d;
      end
   end

   assign acc_cnt = acc_cnt_q;

   buf1_5 #(.W(W)) u_buf_wb (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[CH_WB]),
      .din       (in_data),
      .out_ready (out_ready[CH_WB]),
      .out_valid (out_valid[CH_WB]),
      .out_data  (out_data0)
   );

   buf1_5 #(.W(W)) u_buf_dbg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[CH_DBG]),
      .din       (in_data),
      .out_ready (out_ready[CH_DBG]),
      .out_valid (out_valid[CH_DBG]),
      .out_data  (out_data1)
   );

   buf1_5 #(.W(W)) u_buf_cp0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[CH_CP0]),
      .din       (in_data),
      .out_ready (out_ready[CH_CP0]),
      .out_valid (out_valid[CH_CP0]),
      .out_data  (out_data2)
   );

   buf1_5 #(.W(W)) u_buf_spare (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[CH_SPARE]),
      .din       (in_data),
      .out_ready (out_ready[CH_SPARE]),
      .out_valid (out_valid[CH_SPARE]),
      .out_data  (out_data3)
   );

endmodule

// File: tb/tb_demux1to4_5_buf.sv
// tb_demux1to4_5_buf
//   Directed self-checking bench for demux1to4_5_buf.
module tb_demux1to4_5_buf;

   localparam int unsigned W     = 5;
   localparam int unsigned CNT_W = 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_sel;
   logic [W-1:0]     in_data;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [W-1:0]     out_data0;
   logic [W-1:0]     out_data1;
   logic [W-1:0]     out_data2;
   logic [W-1:0]     out_data3;
   logic [CNT_W-1:0] acc_cnt;

   int unsigned n_checks;
   int unsigned n_fail;

   demux1to4_5_buf #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3),
      .acc_cnt   (acc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = '0;
      out_ready = 4'b0000;

      // 1. reset and idle
      #2;
      check_eq("in_ready_in_reset", in_ready, 1);
      check_eq("out_valid_in_reset", out_valid, 4'b0000);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check_eq("rst_out_valid", out_valid, 4'b0000);
      check_eq("rst_acc_cnt", acc_cnt, 0);
      check_eq("rst_out_data0", out_data0, 0);
      check_eq("rst_out_data3", out_data3, 0);
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         check_eq($sformatf("idle_in_ready_sel%0d", s), in_ready, 1);
      end

      // 2. single routing to channel 2
      in_sel   = 2'd2;
      in_data  = 5'h1A;
      in_valid = 1'b1;
      #1;
      check_eq("t2_in_ready_pre", in_ready, 1);
      tick();
      check_eq("t2_out_valid", out_valid, 4'b0100);
      check_eq("t2_out_data2", out_data2, 5'h1A);
      check_eq("t2_acc_cnt", acc_cnt, 1);
      check_eq("t2_in_ready_full", in_ready, 0);
      // held off: no accept while channel 2 is full and not draining
      in_data = 5'h03;
      tick();
      check_eq("t2_hold_acc_cnt", acc_cnt, 1);
      check_eq("t2_hold_out_data2", out_data2, 5'h1A);

      // 3. simultaneous drain and accept on channel 2
      in_data   = 5'h05;
      out_ready = 4'b0100;
      #1;
      check_eq("t3_in_ready_release", in_ready, 1);
      tick();
      check_eq("t3_out_data2", out_data2, 5'h05);
      check_eq("t3_out_valid", out_valid, 4'b0100);
      check_eq("t3_acc_cnt", acc_cnt, 2);
      // drain without accept: valid clears, data holds
      in_valid = 1'b0;
      tick();
      check_eq("t3_drain_out_valid", out_valid, 4'b0000);
      check_eq("t3_drain_out_data2", out_data2, 5'h05);
      out_ready = 4'b0000;

      // 4. independence: channel 0 stalled, channels 1 and 3 accept
      in_valid = 1'b1;
      in_sel   = 2'd0;
      in_data  = 5'h0A;
      tick();
      in_sel  = 2'd1;
      in_data = 5'h11;
      #1;
      check_eq("t4_in_ready_sel1", in_ready, 1);
      tick();
      in_sel  = 2'd3;
      in_data = 5'h1F;
      #1;
      check_eq("t4_in_ready_sel3", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check_eq("t4_out_valid", out_valid, 4'b1011);
      check_eq("t4_out_data0", out_data0, 5'h0A);
      check_eq("t4_out_data1", out_data1, 5'h11);
      check_eq("t4_out_data3", out_data3, 5'h1F);
      check_eq("t4_acc_cnt", acc_cnt, 5);
      in_sel = 2'd0;
      #1;
      check_eq("t4_in_ready_sel0_full", in_ready, 0);
      in_sel = 2'd2;
      #1;
      check_eq("t4_in_ready_sel2_empty", in_ready, 1);
      // ready on an empty channel is ignored
      out_ready = 4'b0100;
      tick();
      check_eq("t4_ready_on_empty", out_valid, 4'b1011);

      // 5. streaming on channel 0
      out_ready = 4'b1111;
      tick();
      check_eq("t5_all_drained", out_valid, 4'b0000);
      out_ready = 4'b0001;
      in_sel    = 2'd0;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 5'(i);
         #1;
         check_eq($sformatf("t5_in_ready_%0d", i), in_ready, 1);
         tick();
         check_eq($sformatf("t5_out_data0_%0d", i), out_data0, 5'(i));
         check_eq($sformatf("t5_out_valid_%0d", i), out_valid, 4'b0001);
      end
      in_valid = 1'b0;
      check_eq("t5_acc_cnt", acc_cnt, 13);
      tick();
      check_eq("t5_tail_drained", out_valid, 4'b0000);

      // 6a. asynchronous reset with all channels full
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_sel  = 2'(k);
         in_data = 5'(k + 16);
         tick();
      end
      in_valid = 1'b0;
      check_eq("t6_all_full", out_valid, 4'b1111);
      check_eq("t6_out_data3_pre", out_data3, 5'h13);
      check_eq("t6_acc_cnt_pre", acc_cnt, 17);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6_async_out_valid", out_valid, 4'b0000);
      check_eq("t6_async_out_data1", out_data1, 0);
      check_eq("t6_async_acc_cnt", acc_cnt, 0);
      check_eq("t6_async_in_ready", in_ready, 1);
      tick();
      rst_n = 1'b1;

      // 6b. counter wrap after 256 accepts
      out_ready = 4'b1111;
      in_sel    = 2'd1;
      in_valid  = 1'b1;
      for (int i = 0; i < 255; i++) begin
         in_data = 5'(i);
         tick();
      end
      check_eq("t6_acc_cnt_255", acc_cnt, 255);
      tick();
      in_valid = 1'b0;
      check_eq("t6_acc_cnt_wrap", acc_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
